// File: rtl/padding_row_sequencer.sv
// padding_row_sequencer
//   Walks padding_top through one channel-plane of IMG_H rows: fetches each
//   row from the line/feature memory, drives padding_top's en/count/
//   imgDataValid/wait_en, and hands every completed 3-row window to the 3x3
//   conv stage over a valid/ready handshake. After the last row a single
//   all-zero row is pushed in to form the bottom-padded final window.
//
//   Optional feature (compile-time macro PAD_SEQ_STALL_CNT_EN):
//     defined     -> stall_cycles_o counts cycles where a window is offered
//                    but not accepted; cleared on an accepted start,
//                    saturating at 2^32-1 and holding its value after the
//                    frame ends.
//     not defined -> stall_cycles_o is tied to zero.

module padding_row_sequencer #(
    parameter int IMG_H  = 416,
    parameter int CNT_W  = 9,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_ack_i,
    input  logic              rd_valid_i,
    output logic              pad_en_o,
    output logic [CNT_W-1:0]  pad_count_o,
    output logic              pad_img_valid_o,
    output logic              pad_wait_en_o,
    output logic              pad_zero_o,
    output logic              win_valid_o,
    input  logic              win_ready_i,
    output logic [CNT_W-1:0]  win_row_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [31:0]       stall_cycles_o
);

    // Frame sequencing states.
    //   IDLE  : waiting for start
    //   REQ   : row read request outstanding until the memory acks it
    //   DATA  : waiting for the requested row to appear on the data bus
    //   WIN   : window (rows row_idx-2..row_idx) offered to the conv stage
    //   FLUSH : one cycle pushing an all-zero row in as bottom padding
    //   WINL  : final, bottom-padded window offered to the conv stage
    //   DONE  : one-cycle end-of-frame pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_WIN,
        S_FLUSH,
        S_WINL,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(IMG_H);

    state_t              state_q;
    logic [CNT_W-1:0]    row_idx_q;
    logic                rd_req_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                pad_en_q;
    logic [CNT_W-1:0]    pad_count_q;
    logic                pad_zero_q;
    logic                win_valid_q;
    logic [CNT_W-1:0]    win_row_q;
    logic                frame_done_q;

    logic [CNT_W-1:0]    row_inc;

    assign row_inc = row_idx_q + CNT_W'(1);

    // Frame FSM with registered outputs; every output is loaded on the
    // transition into the state that owns it, so it is clean from the flop.
    // NOTE: sequential state is only ever written with <= so every flop in
    // this block samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        // NOTE: abort shares the reset branch so it wins over every other
        // transition, including a start in the same cycle.
        if (reset_i || abort_i) begin
            state_q      <= S_IDLE;
            row_idx_q    <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            pad_en_q     <= 1'b0;
            pad_count_q  <= '0;
            pad_zero_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_REQ;
                        row_idx_q   <= '0;
                        pad_en_q    <= 1'b1;
                        rd_req_q    <= 1'b1;
                        rd_addr_q   <= '0;
                        pad_count_q <= '0;
                    end
                end

                S_REQ: begin
                    // Request stays up, address stable, until accepted.
                    if (rd_ack_i) begin
                        state_q  <= S_DATA;
                        rd_req_q <= 1'b0;
                    end
                end

                S_DATA: begin
                    if (rd_valid_i) begin
                        if (row_idx_q == '0) begin
                            // First row alone cannot form a window; fetch
                            // the second one straight away.
                            state_q     <= S_REQ;
                            row_idx_q   <= row_inc;
                            rd_req_q    <= 1'b1;
                            rd_addr_q   <= ADDR_W'(row_inc);
                            pad_count_q <= row_inc;
                        end else begin
                            state_q     <= S_WIN;
                            win_valid_q <= 1'b1;
                            win_row_q   <= row_idx_q - CNT_W'(1);
                        end
                    end
                end

                S_WIN: begin
                    if (win_ready_i) begin
                        win_valid_q <= 1'b0;
                        if (row_idx_q == LAST_ROW) begin
                            state_q     <= S_FLUSH;
                            pad_count_q <= FLUSH_CNT;
                            pad_zero_q  <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            row_idx_q   <= row_inc;
                            rd_req_q    <= 1'b1;
                            rd_addr_q   <= ADDR_W'(row_inc);
                            pad_count_q <= row_inc;
                        end
                    end
                end

                S_FLUSH: begin
                    // Exactly one zero-row cycle, no memory traffic.
                    state_q     <= S_WINL;
                    pad_zero_q  <= 1'b0;
                    win_valid_q <= 1'b1;
                    win_row_q   <= LAST_ROW;
                end

                S_WINL: begin
                    if (win_ready_i) begin
                        state_q      <= S_DONE;
                        win_valid_q  <= 1'b0;
                        win_row_q    <= '0;
                        pad_count_q  <= '0;
                        rd_addr_q    <= '0;
                        frame_done_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_q      <= S_IDLE;
                    row_idx_q    <= '0;
                    pad_en_q     <= 1'b0;
                    frame_done_q <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_req_o     = rd_req_q;
    assign rd_addr_o    = rd_addr_q;
    assign pad_en_o     = pad_en_q;
    assign pad_count_o  = pad_count_q;
    assign pad_zero_o   = pad_zero_q;
    assign win_valid_o  = win_valid_q;
    assign win_row_o    = win_row_q;
    assign frame_done_o = frame_done_q;

    // imgDataValid must line up with the data beat itself, so it follows
    // rd_valid combinationally while a row is awaited; the zero row is
    // always valid during FLUSH. rd_valid in any other state is ignored.
    assign pad_img_valid_o = ((state_q == S_DATA) && rd_valid_i) || (state_q == S_FLUSH);

    // Rows in padding_top are frozen while the conv stage back-pressures.
    assign pad_wait_en_o = win_valid_q && !win_ready_i;

    assign busy_o = (state_q != S_IDLE);

`ifdef PAD_SEQ_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        start_accept;

    assign start_accept = (state_q == S_IDLE) && start_i;

    // Back-pressure counter: cleared on an accepted start, saturating.
    always_ff @(posedge clk_i) begin
        if (reset_i || abort_i) begin
            stall_q <= '0;
        end else if (start_accept) begin
            stall_q <= '0;
        end else if (win_valid_q && !win_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_padding_row_sequencer.sv
// Self-checking bench for padding_row_sequencer (IMG_H = 4).
// A randomized memory / conv-stage responder drives the handshakes; the
// expected frame is described at transaction level: reads 0..H-1 in order,
// windows 0..H-1 in order, one zero flush, one done pulse, and wait_en
// cycles equal to the back-pressure the responder chose to apply.

module tb_padding_row_sequencer;

    localparam int H      = 4;
    localparam int CNT_W  = 9;
    localparam int ADDR_W = 9;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              start_i;
    logic              abort_i;
    logic              rd_req_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              rd_ack_i;
    logic              rd_valid_i;
    logic              pad_en_o;
    logic [CNT_W-1:0]  pad_count_o;
    logic              pad_img_valid_o;
    logic              pad_wait_en_o;
    logic              pad_zero_o;
    logic              win_valid_o;
    logic              win_ready_i;
    logic [CNT_W-1:0]  win_row_o;
    logic              busy_o;
    logic              frame_done_o;
    logic [31:0]       stall_cycles_o;

    int vectors     = 0;
    int miscompares = 0;

    padding_row_sequencer #(
        .IMG_H (H),
        .CNT_W (CNT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .rd_req_o       (rd_req_o),
        .rd_addr_o      (rd_addr_o),
        .rd_ack_i       (rd_ack_i),
        .rd_valid_i     (rd_valid_i),
        .pad_en_o       (pad_en_o),
        .pad_count_o    (pad_count_o),
        .pad_img_valid_o(pad_img_valid_o),
        .pad_wait_en_o  (pad_wait_en_o),
        .pad_zero_o     (pad_zero_o),
        .win_valid_o    (win_valid_o),
        .win_ready_i    (win_ready_i),
        .win_row_o      (win_row_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .stall_cycles_o (stall_cycles_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Everything quiet: used after reset, abort and idle-only stimulus.
    task automatic check_idle(input string tag);
        check({tag, ".busy"},       64'(busy_o),          64'd0);
        check({tag, ".rd_req"},     64'(rd_req_o),        64'd0);
        check({tag, ".rd_addr"},    64'(rd_addr_o),       64'd0);
        check({tag, ".pad_en"},     64'(pad_en_o),        64'd0);
        check({tag, ".pad_count"},  64'(pad_count_o),     64'd0);
        check({tag, ".img_valid"},  64'(pad_img_valid_o), 64'd0);
        check({tag, ".wait_en"},    64'(pad_wait_en_o),   64'd0);
        check({tag, ".pad_zero"},   64'(pad_zero_o),      64'd0);
        check({tag, ".win_valid"},  64'(win_valid_o),     64'd0);
        check({tag, ".win_row"},    64'(win_row_o),       64'd0);
        check({tag, ".frame_done"}, 64'(frame_done_o),    64'd0);
        check({tag, ".stall"},      64'(stall_cycles_o),  64'd0);
    endtask

    // Runs one frame. ack/valid delays and window stalls are drawn from the
    // given ranges; fix_row/fix_len force a stall length on one window.
    // abort_row >= 0 aborts while that window is offered; reset_row >= 0
    // applies reset while that row's data is awaited. Either returns early.
    task automatic run_frame(input int ack_min, input int ack_max,
                             input int val_min, input int val_max,
                             input int stall_max, input int fix_row, input int fix_len,
                             input int abort_row, input int reset_row,
                             input bit start_noise);
        int  reads[$];
        int  wins[$];
        int  ack_cnt, val_cnt, stall_cnt, cur_addr;
        int  flushes, waits, stall_sum;
        bit  req_seen, pending, was_pending, win_seen;
        bit  data_now, flush_now, flush_next, done, exit_now, exited;
        bit  prev_req, prev_ack, prev_wv, prev_wr;
        logic [63:0] exp_stall;

        ack_cnt = 0; val_cnt = 0; stall_cnt = 0; cur_addr = 0;
        flushes = 0; waits = 0; stall_sum = 0;
        req_seen = 0; pending = 0; win_seen = 0;
        flush_next = 0; done = 0; exited = 0;
        prev_req = 0; prev_ack = 0; prev_wv = 0; prev_wr = 0;

        @(negedge clk_i);
        start_i = 1'b1; abort_i = 1'b0; reset_i = 1'b0;
        rd_ack_i = 1'b0; rd_valid_i = 1'b0; win_ready_i = 1'b0;
        #1;
        check("start.idle_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i);

        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk_i);
            start_i  = start_noise && ($urandom_range(3, 0) == 0);
            exit_now = 1'b0;

            // Memory data bus: deliver after the chosen delay, else noise.
            was_pending = pending;
            data_now    = 1'b0;
            if (pending) begin
                if (val_cnt == 0) begin
                    data_now = 1'b1;
                    pending  = 1'b0;
                end else begin
                    val_cnt--;
                end
            end
            rd_valid_i = data_now || (!was_pending && ($urandom_range(3, 0) == 0));

            // Memory request port.
            rd_ack_i = 1'b0;
            if (rd_req_o) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    ack_cnt  = int'($urandom_range(ack_max, ack_min));
                end
                if (ack_cnt == 0) begin
                    rd_ack_i = 1'b1;
                    req_seen = 1'b0;
                    pending  = 1'b1;
                    val_cnt  = int'($urandom_range(val_max, val_min));
                    cur_addr = reads.size();
                end else begin
                    ack_cnt--;
                end
            end

            // Conv stage.
            if (win_valid_o) begin
                if (!win_seen) begin
                    win_seen  = 1'b1;
                    stall_cnt = (int'(win_row_o) == fix_row) ? fix_len
                                                              : int'($urandom_range(stall_max, 0));
                    stall_sum += stall_cnt;
                end
                if (stall_cnt == 0) begin
                    win_ready_i = 1'b1;
                    win_seen    = 1'b0;
                end else begin
                    win_ready_i = 1'b0;
                    stall_cnt--;
                end
            end else begin
                win_ready_i = 1'($urandom_range(1, 0));
            end

            if (abort_row >= 0 && win_valid_o && int'(win_row_o) == abort_row) begin
                abort_i     = 1'b1;
                win_ready_i = 1'b0;
                exit_now    = 1'b1;
            end
            if (reset_row >= 0 && was_pending && cur_addr == reset_row) begin
                reset_i    = 1'b1;
                rd_valid_i = 1'b0;
                data_now   = 1'b0;
                exit_now   = 1'b1;
            end

            #1;
            flush_now  = flush_next;
            flush_next = 1'b0;
            check("frame.busy",      64'(busy_o),          64'd1);
            check("frame.pad_en",    64'(pad_en_o),        64'd1);
            check("frame.img_valid", 64'(pad_img_valid_o), 64'(data_now || flush_now));
            check("frame.pad_zero",  64'(pad_zero_o),      64'(flush_now));
            if (flush_now) begin
                check("flush.pad_count", 64'(pad_count_o), 64'(H));
                check("flush.no_req",    64'(rd_req_o),    64'd0);
                flushes++;
            end
            if (data_now) check("data.pad_count", 64'(pad_count_o), 64'(cur_addr));
            if (rd_req_o) begin
                check("req.rd_addr",   64'(rd_addr_o),   64'(reads.size()));
                check("req.pad_count", 64'(pad_count_o), 64'(reads.size()));
            end
            if (win_valid_o) begin
                check("win.row",    64'(win_row_o), 64'(wins.size()));
                check("win.no_req", 64'(rd_req_o),  64'd0);
            end
            if (win_ready_i) check("win.wait_low", 64'(pad_wait_en_o), 64'd0);
            if (prev_req && !prev_ack) check("req.held", 64'(rd_req_o), 64'd1);
            if (prev_wv && !prev_wr)   check("win.held", 64'(win_valid_o), 64'd1);
            if (pad_wait_en_o) waits++;

            if (rd_req_o && rd_ack_i) reads.push_back(int'(rd_addr_o));
            if (win_valid_o && win_ready_i) begin
                wins.push_back(int'(win_row_o));
                if (wins.size() == H - 1) flush_next = 1'b1;
            end
            if (frame_done_o) begin
                check("done.after_windows", 64'(wins.size()), 64'(H));
                done = 1'b1;
            end

            prev_req = rd_req_o;
            prev_ack = rd_ack_i;
            prev_wv  = win_valid_o;
            prev_wr  = win_ready_i;
            @(posedge clk_i);
            if (exit_now) begin
                exited = 1'b1;
                break;
            end
        end

        if (abort_row >= 0 || reset_row >= 0) begin
            if (!exited) check("frame.exit_not_reached", 64'd0, 64'd1);
        end else begin
            if (!done) check("frame.timeout", 64'd0, 64'd1);
            check("frame.read_count", 64'(reads.size()), 64'(H));
            foreach (reads[i]) check("frame.read_order", 64'(reads[i]), 64'(i));
            check("frame.win_count", 64'(wins.size()), 64'(H));
            foreach (wins[i]) check("frame.win_order", 64'(wins[i]), 64'(i));
            check("frame.flushes", 64'(flushes), 64'd1);
            check("frame.wait_cycles", 64'(waits), 64'(stall_sum));

            @(negedge clk_i);
            start_i = 1'b0; rd_ack_i = 1'b0; rd_valid_i = 1'b0; win_ready_i = 1'b0;
            #1;
`ifdef PAD_SEQ_STALL_CNT_EN
            exp_stall = 64'(stall_sum);
`else
            exp_stall = 64'd0;
`endif
            check("post.busy",       64'(busy_o),         64'd0);
            check("post.pad_en",     64'(pad_en_o),       64'd0);
            check("post.frame_done", 64'(frame_done_o),   64'd0);
            check("post.win_valid",  64'(win_valid_o),    64'd0);
            check("post.stall",      64'(stall_cycles_o), exp_stall);
        end
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        rd_ack_i = 1'b0; rd_valid_i = 1'b0; win_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check_idle("reset");
        reset_i = 1'b0;
        @(negedge clk_i);
        #1;
        check_idle("after_reset");

        // Zero-latency memory, conv stage always ready.
        run_frame(0, 0, 0, 0, 0, -1, 0, -1, -1, 1'b0);

        // Window 1 back-pressured for 5 cycles.
        run_frame(0, 0, 0, 0, 0, 1, 5, -1, -1, 1'b0);

        // Ack delayed 3 cycles, data 2 more.
        run_frame(3, 3, 2, 2, 0, -1, 0, -1, -1, 1'b0);

        // Abort while window 2 is offered; late rd_valid must be ignored.
        run_frame(0, 1, 0, 1, 1, -1, 0, 2, -1, 1'b0);
        @(negedge clk_i);
        abort_i = 1'b0; rd_valid_i = 1'b1; rd_ack_i = 1'b0; win_ready_i = 1'b0; start_i = 1'b0;
        #1;
        check_idle("abort");
        rd_valid_i = 1'b0;
        run_frame(0, 2, 0, 2, 2, -1, 0, -1, -1, 1'b0);

        // start and abort together in IDLE: stays idle.
        @(negedge clk_i);
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0;
        #1;
        check_idle("start_abort");
        @(negedge clk_i);
        #1;
        check("start_abort.still_idle", 64'(busy_o), 64'd0);

        // Random latencies and stalls with start pulses while busy.
        repeat (6) run_frame(0, 3, 0, 3, 3, -1, 0, -1, -1, 1'b1);

        // Reset while row 1 is awaited; rd_valid arriving next cycle.
        run_frame(0, 2, 1, 2, 0, -1, 0, -1, 1, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0; rd_valid_i = 1'b1; rd_ack_i = 1'b0; win_ready_i = 1'b0;
        #1;
        check_idle("reset_data");
        @(negedge clk_i);
        rd_valid_i = 1'b0;
        #1;
        check_idle("reset_data_next");

        run_frame(0, 3, 0, 3, 3, -1, 0, -1, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
